pkt_fifo: RTL and testbench

Single-clock, packet-aware store-and-forward FIFO for the offload datapath. Words are written speculatively and become readable only when a packet is committed with its last word; overflowed or aborted packets are rewound. The read side streams whole packets with a last marker and can skip the rest of a packet. It is the generalised successor of the length-driven read queue, with arbitrary depth, a packet length queue, and drop/skip support.

---
 rtl/pkt_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_pkt_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_fifo.sv
// pkt_fifo: single-clock packet store-and-forward FIFO with speculative writes, commit on last,
// overflow/abort rewind and head-packet skip. Define PKT_FIFO_ABORT_EN to build the i_wr_abort path.
module pkt_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 2048,
    parameter  int MAX_PKTS   = 16,
    localparam int LEN_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rstn,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    input  logic                  i_wr_abort,
    output logic                  o_wr_full,
    output logic                  o_wr_drop,
    input  logic                  i_rd_en,
    input  logic                  i_rd_skip,
    output logic                  o_pkt_avail,
    output logic [LEN_W-1:0]      o_pkt_len,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_last,
    output logic                  o_rd_done,
    output logic [LEN_W-1:0]      o_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int QW    = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
    localparam int CNT_W = $clog2(MAX_PKTS + 1);
    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [QW-1:0]    LAST_QIDX = QW'(MAX_PKTS - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] q);
        return (q == LAST_QIDX) ? '0 : q + QW'(1);
    endfunction

    // Advance by up to FIFO_DEPTH words; one conditional subtract covers the wrap.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [LEN_W-1:0] n);
        logic [LEN_W:0] sum;
        sum = (LEN_W+1)'(p) + (LEN_W+1)'(n);
        if (sum >= (LEN_W+1)'(FIFO_DEPTH)) sum = sum - (LEN_W+1)'(FIFO_DEPTH);
        return PTR_W'(sum);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [LEN_W-1:0]      len_mem_q [MAX_PKTS];

    logic [PTR_W-1:0]      w_ptr_q, w_ptr_d, wc_ptr_q, wc_ptr_d, r_ptr_q, r_ptr_d;
    logic [LEN_W-1:0]      open_len_q, open_len_d, level_q, level_d, rem_q, rem_d;
    logic                  err_q, err_d, started_q, started_d;
    logic [QW-1:0]         len_head_q, len_tail_q;
    logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic                  drop_q, drop_d;
    logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_done_q, rd_done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  full, avail, abort_fire, ram_we, push, pop, lvl_inc;
    logic [LEN_W-1:0]      head_len, cur_rem, lvl_wr_dec, lvl_rd_dec;

    assign full     = (level_q == LEN_W'(FIFO_DEPTH)) || (pkt_cnt_q == CNT_W'(MAX_PKTS));
    assign avail    = (pkt_cnt_q != '0);
    assign head_len = len_mem_q[len_head_q];
    assign cur_rem  = started_q ? rem_q : head_len;

`ifdef PKT_FIFO_ABORT_EN
    assign abort_fire = i_wr_abort && ((open_len_q != '0) || err_q);
`else
    logic unused_abort;
    assign unused_abort = i_wr_abort;
    assign abort_fire   = 1'b0;
`endif

    // Write side: speculative store, commit on last, rewind on abort or errored last.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_ptr_d    = w_ptr_q;
        wc_ptr_d   = wc_ptr_q;
        open_len_d = open_len_q;
        err_d      = err_q;
        drop_d     = 1'b0;
        ram_we     = 1'b0;
        push       = 1'b0;
        lvl_inc    = 1'b0;
        lvl_wr_dec = '0;
        if (abort_fire) begin
            w_ptr_d    = wc_ptr_q;
            open_len_d = '0;
            err_d      = 1'b0;
            drop_d     = 1'b1;
            lvl_wr_dec = open_len_q;
        end else if (i_wr_en) begin
            if (!full) begin
                ram_we     = 1'b1;
                w_ptr_d    = ptr_inc(w_ptr_q);
                open_len_d = open_len_q + LEN_W'(1);
                lvl_inc    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            if (i_wr_last) begin
                if (err_q || full) begin
                    w_ptr_d    = wc_ptr_q;
                    open_len_d = '0;
                    err_d      = 1'b0;
                    drop_d     = 1'b1;
                    lvl_inc    = 1'b0;
                    lvl_wr_dec = open_len_q;
                end else begin
                    push       = 1'b1;
                    wc_ptr_d   = ptr_inc(w_ptr_q);
                    open_len_d = '0;
                end
            end
        end
    end

    // Read side: pop one word or skip the remainder of the head packet.
    always_comb begin
        r_ptr_d    = r_ptr_q;
        rem_d      = rem_q;
        started_d  = started_q;
        pop        = 1'b0;
        lvl_rd_dec = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = '0;
        rd_last_d  = 1'b0;
        rd_done_d  = 1'b0;
        if (avail) begin
            if (i_rd_skip) begin
                r_ptr_d    = ptr_add(r_ptr_q, cur_rem);
                pop        = 1'b1;
                started_d  = 1'b0;
                lvl_rd_dec = cur_rem;
                rd_done_d  = 1'b1;
            end else if (i_rd_en) begin
                rd_valid_d = 1'b1;
                rd_data_d  = mem_q[r_ptr_q];
                r_ptr_d    = ptr_inc(r_ptr_q);
                lvl_rd_dec = LEN_W'(1);
                if (cur_rem == LEN_W'(1)) begin
                    rd_last_d = 1'b1;
                    rd_done_d = 1'b1;
                    pop       = 1'b1;
                    started_d = 1'b0;
                end else begin
                    rem_d     = cur_rem - LEN_W'(1);
                    started_d = 1'b1;
                end
            end
        end
    end

    assign level_d   = level_q + LEN_W'(lvl_inc) - lvl_wr_dec - lvl_rd_dec;
    assign pkt_cnt_d = pkt_cnt_q + CNT_W'(push) - CNT_W'(pop);

    // NOTE: storage arrays carry no reset; pointers and counts alone define what is valid.
    always_ff @(posedge i_sys_clk) begin
        if (ram_we) mem_q[w_ptr_q] <= i_wr_data;
        if (push)   len_mem_q[len_tail_q] <= open_len_q + LEN_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rstn) begin
            w_ptr_q    <= '0;
            wc_ptr_q   <= '0;
            r_ptr_q    <= '0;
            open_len_q <= '0;
            level_q    <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            started_q  <= 1'b0;
            len_head_q <= '0;
            len_tail_q <= '0;
            pkt_cnt_q  <= '0;
            drop_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            w_ptr_q    <= w_ptr_d;
            wc_ptr_q   <= wc_ptr_d;
            r_ptr_q    <= r_ptr_d;
            open_len_q <= open_len_d;
            level_q    <= level_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            started_q  <= started_d;
            if (pop)  len_head_q <= q_inc(len_head_q);
            if (push) len_tail_q <= q_inc(len_tail_q);
            pkt_cnt_q  <= pkt_cnt_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            rd_done_q  <= rd_done_d;
        end
    end

    assign o_wr_full   = full;
    assign o_wr_drop   = drop_q;
    assign o_pkt_avail = avail;
    assign o_pkt_len   = avail ? head_len : '0;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_last   = rd_last_q;
    assign o_rd_done   = rd_done_q;
    assign o_level     = level_q;

endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo: directed scenarios plus randomized traffic against a packet-queue reference model.
// Small geometry (12 words, 3 packets) so wrap, overflow and length-queue-full all occur.
module tb_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int MAXP  = 3;
    localparam int LW    = $clog2(DEPTH + 1);
`ifdef PKT_FIFO_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_wr_en = 1'b0, i_wr_last = 1'b0, i_wr_abort = 1'b0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_rd_en = 1'b0, i_rd_skip = 1'b0;
    logic          o_wr_full, o_wr_drop, o_pkt_avail, o_rd_valid, o_rd_last, o_rd_done;
    logic [LW-1:0] o_pkt_len, o_level;
    logic [DW-1:0] o_rd_data;

    always #5 clk = ~clk;

    pkt_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_PKTS(MAXP)) dut (
        .i_sys_clk  (clk),
        .i_rstn     (i_rstn),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_wr_last  (i_wr_last),
        .i_wr_abort (i_wr_abort),
        .o_wr_full  (o_wr_full),
        .o_wr_drop  (o_wr_drop),
        .i_rd_en    (i_rd_en),
        .i_rd_skip  (i_rd_skip),
        .o_pkt_avail(o_pkt_avail),
        .o_pkt_len  (o_pkt_len),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .o_rd_last  (o_rd_last),
        .o_rd_done  (o_rd_done),
        .o_level    (o_level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: committed words as one flat queue plus a queue of packet lengths.
    byte unsigned m_words[$];
    int           m_lens[$];
    int           m_rd_off;
    byte unsigned m_open[$];
    bit           m_err;
    bit           e_drop, e_valid, e_last, e_done;
    byte unsigned e_data;

    task automatic model(input bit rst, input bit wr, input bit last, input bit abort,
                         input bit rd, input bit skip, input byte unsigned d);
        bit full, err0;
        full   = ((m_words.size() + m_open.size()) == DEPTH) || (m_lens.size() == MAXP);
        err0   = m_err;
        e_drop = 0; e_valid = 0; e_last = 0; e_done = 0; e_data = 0;
        if (rst) begin
            m_words.delete(); m_lens.delete(); m_open.delete();
            m_rd_off = 0; m_err = 0;
            return;
        end
        if (m_lens.size() != 0) begin
            if (skip) begin
                repeat (m_lens[0] - m_rd_off) void'(m_words.pop_front());
                void'(m_lens.pop_front());
                m_rd_off = 0;
                e_done   = 1;
            end else if (rd) begin
                e_valid = 1;
                e_data  = m_words.pop_front();
                m_rd_off++;
                if (m_rd_off == m_lens[0]) begin
                    e_last = 1; e_done = 1;
                    void'(m_lens.pop_front());
                    m_rd_off = 0;
                end
            end
        end
        if (ABORT_EN && abort && (m_open.size() != 0 || m_err)) begin
            m_open.delete(); m_err = 0; e_drop = 1;
        end else if (wr) begin
            if (!full) m_open.push_back(d);
            else m_err = 1;
            if (last) begin
                if (err0 || full) begin
                    m_open.delete(); m_err = 0; e_drop = 1;
                end else begin
                    m_lens.push_back(m_open.size());
                    foreach (m_open[i]) m_words.push_back(m_open[i]);
                    m_open.delete();
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit wr, input bit last, input bit abort,
                        input bit rd, input bit skip, input byte unsigned d);
        int lvl;
        i_rstn = !rst; i_wr_en = wr; i_wr_last = last; i_wr_abort = abort;
        i_rd_en = rd; i_rd_skip = skip; i_wr_data = d;
        model(rst, wr, last, abort, rd, skip, d);
        @(posedge clk);
        #1;
        lvl = m_words.size() + m_open.size();
        check("pkt_avail", o_pkt_avail, m_lens.size() != 0);
        check("pkt_len",   o_pkt_len, (m_lens.size() != 0) ? m_lens[0] : 0);
        check("level",     o_level, lvl);
        check("wr_full",   o_wr_full, (lvl == DEPTH) || (m_lens.size() == MAXP));
        check("wr_drop",   o_wr_drop, e_drop);
        check("rd_valid",  o_rd_valid, e_valid);
        check("rd_data",   o_rd_data, e_data);
        check("rd_last",   o_rd_last, e_last);
        check("rd_done",   o_rd_done, e_done);
    endtask

    task automatic wr(input byte unsigned d, input bit last); step(0, 1, last, 0, 0, 0, d); endtask
    task automatic rd();       step(0, 0, 0, 0, 1, 0, 8'h00); endtask
    task automatic skp();      step(0, 0, 0, 0, 0, 1, 8'h00); endtask
    task automatic idle();     step(0, 0, 0, 0, 0, 0, 8'h00); endtask
    task automatic do_reset(); step(1, 0, 0, 0, 0, 0, 8'h00); step(1, 0, 0, 0, 0, 0, 8'h00); endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && o_pkt_avail; i++) rd();
        check("drain_empty", o_pkt_avail, 1'b0);
    endtask

    initial begin
        bit w, l, a, r, s, x;

        do_reset();
        check("rst_level", o_level, 0);
        check("rst_avail", o_pkt_avail, 0);
        check("rst_full",  o_wr_full, 0);

        // Basic 5-word packet.
        for (int i = 0; i < 5; i++) wr(8'(8'h11 + i), i == 4);
        check("p1_avail", o_pkt_avail, 1);
        check("p1_len",   o_pkt_len, 5);
        for (int i = 0; i < 5; i++) begin
            rd();
            check("p1_data", o_rd_data, 8'h11 + i);
            check("p1_last", o_rd_last, i == 4);
        end
        check("p1_level", o_level, 0);

        // Three 5-word packets from reset: the third wraps addresses 10,11,0,1,2.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 5; i++) wr(8'(8'h40 + 16 * p + i), i == 4);
            for (int i = 0; i < 5; i++) begin
                rd();
                check("wrap_data", o_rd_data, 8'h40 + 16 * p + i);
            end
        end

        // Oversized packet: full after 12 words, the rest dropped, whole packet discarded.
        do_reset();
        for (int i = 0; i < 12; i++) wr(8'(i), 0);
        check("ovf_full",  o_wr_full, 1);
        check("ovf_level", o_level, 12);
        wr(8'h0c, 0);
        wr(8'h0d, 1);
        check("ovf_drop",  o_wr_drop, 1);
        check("ovf_level0", o_level, 0);
        check("ovf_avail", o_pkt_avail, 0);
        idle();
        check("ovf_drop_pulse", o_wr_drop, 0);

        // Partial read then skip.
        do_reset();
        for (int i = 0; i < 4; i++) wr(8'(8'h20 + i), i == 3);
        for (int i = 0; i < 4; i++) wr(8'(8'h30 + i), i == 3);
        rd();
        check("skip_first", o_rd_data, 8'h20);
        skp();
        check("skip_done",  o_rd_done, 1);
        check("skip_valid", o_rd_valid, 0);
        check("skip_len",   o_pkt_len, 4);
        check("skip_level", o_level, 4);
        rd();
        check("skip_next",  o_rd_data, 8'h30);
        drain();

        // Length queue full.
        do_reset();
        for (int i = 0; i < MAXP; i++) wr(8'(8'h50 + i), 1);
        check("lq_full",  o_wr_full, 1);
        check("lq_level", o_level, MAXP);
        rd();
        check("lq_free",  o_wr_full, 0);
        drain();

        // Abort alongside a 4th write, then a 5th word with last.
        do_reset();
        wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0);
        step(0, 1, 0, 1, 0, 0, 8'h04);
`ifdef PKT_FIFO_ABORT_EN
        check("ab_drop",  o_wr_drop, 1);
        check("ab_level", o_level, 0);
`else
        check("ab_drop",  o_wr_drop, 0);
        check("ab_level", o_level, 4);
`endif
        wr(8'h05, 1);
        check("ab_len", o_pkt_len, ABORT_EN ? 1 : 5);
        drain();
        wr(8'ha0, 0); wr(8'ha1, 1);
        rd();
        check("ab_p2_w0", o_rd_data, 8'ha0);
        rd();
        check("ab_p2_w1", o_rd_data, 8'ha1);
        check("ab_p2_last", o_rd_last, 1);

        // Randomized mixed traffic, occasional mid-stream reset.
        for (int c = 0; c < 4000; c++) begin
            w = ($urandom_range(0, 99) < 55);
            l = ($urandom_range(0, 99) < 20);
            a = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 99) < 50);
            s = ($urandom_range(0, 99) < 5);
            x = ($urandom_range(0, 999) == 0);
            step(x, w, l, a, r, s, 8'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
